// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one memory port between the I-cache (port 0) and D-cache (port 1).
// Ownership is held across locked bursts, and accepted reads are tagged so their data returns to the right cache.
module mem_arbiter #(
    parameter int RD_LAT   = 2,
    parameter int MAX_HOLD = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_rd,
    input  logic        req1_rd,
    input  logic        req0_wr,
    input  logic        req1_wr,
    input  logic [15:0] req0_addr,
    input  logic [15:0] req1_addr,
    input  logic [15:0] req0_wdata,
    input  logic [15:0] req1_wdata,
    input  logic        req0_lock,
    input  logic        req1_lock,
    output logic        req0_gnt,
    output logic        req1_gnt,
    output logic        req0_stall,
    output logic        req1_stall,
    output logic        req0_rvalid,
    output logic        req1_rvalid,
    output logic [15:0] rdata,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_stall,
    output logic        err
);

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t state, state_next;

    logic          last_owner;
    logic [HW-1:0] hold_cnt, hold_next;
    logic          out_en;
    logic [RD_LAT-1:0] tag_valid, tag_owner;

    logic req0, req1;
    logic owning, owner;
    logic own_req, own_lock, oth_req;
    logic acc;

    assign req0 = req0_rd | req0_wr;
    assign req1 = req1_rd | req1_wr;

    assign owning   = (state != IDLE);
    assign owner    = (state == OWN1);
    assign own_req  = owner ? req1 : req0;
    assign own_lock = owner ? req1_lock : req0_lock;
    assign oth_req  = owner ? req0 : req1;

    assign req0_gnt = (state == OWN0);
    assign req1_gnt = (state == OWN1);

    // Only the owner's request reaches memory; a write wins over a simultaneous read.
    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = 16'h0000;
        mem_wdata = 16'h0000;
        if (state == OWN0) begin
            mem_wr    = req0_wr;
            mem_rd    = req0_rd & ~req0_wr;
            mem_addr  = req0_addr;
            mem_wdata = req0_wdata;
        end else if (state == OWN1) begin
            mem_wr    = req1_wr;
            mem_rd    = req1_rd & ~req1_wr;
            mem_addr  = req1_addr;
            mem_wdata = req1_wdata;
        end
    end

    assign acc = owning & own_req & ~mem_stall;

    // out_en keeps the stalls quiet in the first cycle after a reset edge.
    assign req0_stall = out_en & req0 & ~(req0_gnt & ~mem_stall);
    assign req1_stall = out_en & req1 & ~(req1_gnt & ~mem_stall);

    assign req0_rvalid = tag_valid[RD_LAT-1] & ~tag_owner[RD_LAT-1];
    assign req1_rvalid = tag_valid[RD_LAT-1] &  tag_owner[RD_LAT-1];
    assign rdata       = mem_rdata;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req0 && req1)
                    state_next = last_owner ? OWN0 : OWN1;
                else if (req0)
                    state_next = OWN0;
                else if (req1)
                    state_next = OWN1;
            end
            OWN0, OWN1: begin
                if (mem_stall && own_req)
                    state_next = state;
                else if (own_lock)
                    state_next = state;
                else if (oth_req)
                    state_next = owner ? OWN0 : OWN1;
                else if (own_req)
                    state_next = state;
                else
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Starvation counter: restarts on every ownership change, saturates at the limit.
    always_comb begin
        hold_next = hold_cnt;
        if (state_next != state)
            hold_next = '0;
        else if (owning && oth_req && (hold_cnt != HOLD_MAX))
            hold_next = hold_cnt + HW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            last_owner <= 1'b0;
            hold_cnt   <= '0;
            err        <= 1'b0;
            tag_valid  <= '0;
            tag_owner  <= '0;
            out_en     <= 1'b0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_next;
            out_en   <= 1'b1;
            if (owning && (state_next != state))
                last_owner <= owner;
            if (hold_next == HOLD_MAX)
                err <= 1'b1;
            tag_valid[0] <= acc & mem_rd;
            tag_owner[0] <= owner;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_owner[i] <= tag_owner[i-1];
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter: each row drives one cycle of inputs and the outputs expected in that cycle.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_rd, req1_rd, req0_wr, req1_wr;
    logic [15:0] req0_addr, req1_addr, req0_wdata, req1_wdata;
    logic        req0_lock, req1_lock;
    logic        req0_gnt, req1_gnt, req0_stall, req1_stall;
    logic        req0_rvalid, req1_rvalid;
    logic [15:0] rdata;
    logic        mem_rd, mem_wr;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_stall;
    logic        err;

    always #5 clk = ~clk;

    mem_arbiter #(.RD_LAT(2), .MAX_HOLD(16)) dut (
        .clk(clk), .rst(rst),
        .req0_rd(req0_rd), .req1_rd(req1_rd),
        .req0_wr(req0_wr), .req1_wr(req1_wr),
        .req0_addr(req0_addr), .req1_addr(req1_addr),
        .req0_wdata(req0_wdata), .req1_wdata(req1_wdata),
        .req0_lock(req0_lock), .req1_lock(req1_lock),
        .req0_gnt(req0_gnt), .req1_gnt(req1_gnt),
        .req0_stall(req0_stall), .req1_stall(req1_stall),
        .req0_rvalid(req0_rvalid), .req1_rvalid(req1_rvalid),
        .rdata(rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_stall(mem_stall), .err(err)
    );

    // in_bits = {rst, r0rd, r0wr, r0lock, r1rd, r1wr, r1lock, mem_stall}
    // exp_bits = {gnt0, gnt1, stall0, stall1, rvalid0, rvalid1, mem_rd, mem_wr, err}
    typedef struct {
        string       name;
        logic [7:0]  in_bits;
        logic [15:0] a0;
        logic [15:0] a1;
        logic [8:0]  exp_bits;
    } vec_t;

    localparam logic [7:0] IDLE_IN = 8'b1_000_000_0;

    vec_t vecs[$];
    int   checks = 0;
    int   passed = 0;

    function automatic void add(string nm, logic [7:0] ib, logic [15:0] a0v,
                                logic [15:0] a1v, logic [8:0] eb);
        vec_t v;
        v.name = nm; v.in_bits = ib; v.a0 = a0v; v.a1 = a1v; v.exp_bits = eb;
        vecs.push_back(v);
    endfunction

    task automatic check_val(string nm, int idx, logic [15:0] got, logic [15:0] exp);
        checks++;
        if (got === exp)
            passed++;
        else
            $display("[TB] FAIL %s row %0d: got %h expected %h", nm, idx, got, exp);
    endtask

    task automatic apply_stimulus(vec_t v, int idx);
        {rst, req0_rd, req0_wr, req0_lock, req1_rd, req1_wr, req1_lock, mem_stall} = v.in_bits;
        req0_addr  = v.a0;
        req1_addr  = v.a1;
        req0_wdata = ~v.a0;
        req1_wdata = ~v.a1;
        mem_rdata  = 16'hC000 + 16'(idx);
    endtask

    task automatic check_output(vec_t v, int idx);
        logic [8:0] got;
        got = {req0_gnt, req1_gnt, req0_stall, req1_stall, req0_rvalid, req1_rvalid,
               mem_rd, mem_wr, err};
        check_val({v.name, " flags"}, idx, {7'b0, got}, {7'b0, v.exp_bits});
        if (v.exp_bits[8]) check_val({v.name, " addr"}, idx, mem_addr, v.a0);
        if (v.exp_bits[7]) check_val({v.name, " addr"}, idx, mem_addr, v.a1);
        if (v.exp_bits[1])
            check_val({v.name, " wdata"}, idx, mem_wdata, v.exp_bits[8] ? ~v.a0 : ~v.a1);
        if (v.exp_bits[4] || v.exp_bits[3])
            check_val({v.name, " rdata"}, idx, rdata, 16'hC000 + 16'(idx));
    endtask

    initial begin
        // Collision straight out of reset goes to port 1, then switches with no bubble.
        add("collide",  8'b1_100_100_0, 16'h0100, 16'h0200, 9'b00_11_00_00_0);
        add("collide",  8'b1_100_100_0, 16'h0100, 16'h0200, 9'b01_10_00_10_0);
        add("collide",  8'b1_100_000_0, 16'h0100, 16'h0200, 9'b10_00_00_10_0);
        add("collide",  IDLE_IN,        16'h0100, 16'h0200, 9'b10_00_01_00_0);
        add("collide",  IDLE_IN,        16'h0000, 16'h0000, 9'b00_00_10_00_0);
        add("p1write",  8'b1_000_010_0, 16'h0000, 16'h0300, 9'b00_01_00_00_0);
        add("p1write",  8'b1_000_010_0, 16'h0000, 16'h0300, 9'b01_00_00_01_0);
        add("p1write",  IDLE_IN,        16'h0000, 16'h0300, 9'b01_00_00_00_0);
        add("collide2", 8'b1_100_100_0, 16'h0400, 16'h0500, 9'b00_11_00_00_0);
        add("collide2", 8'b1_100_100_0, 16'h0400, 16'h0500, 9'b10_01_00_10_0);
        add("collide2", 8'b1_000_100_0, 16'h0400, 16'h0500, 9'b01_00_00_10_0);
        add("collide2", IDLE_IN,        16'h0400, 16'h0500, 9'b01_00_10_00_0);
        add("collide2", IDLE_IN,        16'h0000, 16'h0000, 9'b00_00_01_00_0);
        add("single",   8'b1_100_000_0, 16'h1234, 16'h0000, 9'b00_10_00_00_0);
        add("single",   8'b1_100_000_0, 16'h1234, 16'h0000, 9'b10_00_00_10_0);
        add("single",   IDLE_IN,        16'h1234, 16'h0000, 9'b10_00_00_00_0);
        add("single",   IDLE_IN,        16'h0000, 16'h0000, 9'b00_00_10_00_0);
        add("single",   IDLE_IN,        16'h0000, 16'h0000, 9'b00_00_00_00_0);
        // Locked four-word write burst from port 1 while port 0 waits.
        add("burst",    8'b1_000_011_0, 16'h0000, 16'h0800, 9'b00_01_00_00_0);
        add("burst",    8'b1_100_011_0, 16'h0900, 16'h0800, 9'b01_10_00_01_0);
        add("burst",    8'b1_100_011_0, 16'h0900, 16'h0802, 9'b01_10_00_01_0);
        add("burst",    8'b1_100_011_0, 16'h0900, 16'h0804, 9'b01_10_00_01_0);
        add("burst",    8'b1_100_010_0, 16'h0900, 16'h0806, 9'b01_10_00_01_0);
        add("burst",    8'b1_100_000_0, 16'h0900, 16'h0000, 9'b10_00_00_10_0);
        add("burst",    IDLE_IN,        16'h0900, 16'h0000, 9'b10_00_00_00_0);
        add("burst",    IDLE_IN,        16'h0000, 16'h0000, 9'b00_00_10_00_0);
        // Three cycles of mem_stall: access held, no tag until it is accepted.
        add("mstall",   8'b1_100_000_0, 16'h0A00, 16'h0000, 9'b00_10_00_00_0);
        add("mstall",   8'b1_100_000_1, 16'h0A00, 16'h0000, 9'b10_10_00_10_0);
        add("mstall",   8'b1_100_000_1, 16'h0A00, 16'h0000, 9'b10_10_00_10_0);
        add("mstall",   8'b1_100_000_1, 16'h0A00, 16'h0000, 9'b10_10_00_10_0);
        add("mstall",   8'b1_100_000_0, 16'h0A00, 16'h0000, 9'b10_00_00_10_0);
        add("mstall",   IDLE_IN,        16'h0A00, 16'h0000, 9'b10_00_00_00_0);
        add("mstall",   IDLE_IN,        16'h0000, 16'h0000, 9'b00_00_10_00_0);
        // Leave last_owner at 1 so the reset below has something to clear.
        add("p1exit",   8'b1_000_010_0, 16'h0000, 16'h0B00, 9'b00_01_00_00_0);
        add("p1exit",   8'b1_000_010_0, 16'h0000, 16'h0B00, 9'b01_00_00_01_0);
        add("p1exit",   IDLE_IN,        16'h0000, 16'h0B00, 9'b01_00_00_00_0);
        // Starvation: port 1 keeps locked reads going, err rises when hold_cnt hits 16.
        add("starve",   8'b1_000_101_0, 16'h0000, 16'h0C00, 9'b00_01_00_00_0);
        for (int k = 1; k <= 20; k++) begin
            if (k <= 2)
                add("starve", 8'b1_100_101_0, 16'h0D00, 16'h0C00, 9'b01_10_00_10_0);
            else if (k <= 16)
                add("starve", 8'b1_100_101_0, 16'h0D00, 16'h0C00, 9'b01_10_01_10_0);
            else
                add("starve", 8'b1_100_101_0, 16'h0D00, 16'h0C00, 9'b01_10_01_10_1);
        end
        add("rstmid",   8'b0_100_101_0, 16'h0D00, 16'h0C00, 9'b01_10_01_10_1);
        add("rstmid",   IDLE_IN,        16'h0000, 16'h0000, 9'b00_00_00_00_0);
        add("rstmid",   IDLE_IN,        16'h0000, 16'h0000, 9'b00_00_00_00_0);
        add("postrst",  8'b1_100_100_0, 16'h0E00, 16'h0F00, 9'b00_11_00_00_0);
        add("postrst",  8'b1_100_100_0, 16'h0E00, 16'h0F00, 9'b01_10_00_10_0);
        add("postrst",  8'b1_100_000_0, 16'h0E00, 16'h0F00, 9'b10_00_00_10_0);
        add("postrst",  IDLE_IN,        16'h0E00, 16'h0000, 9'b10_00_01_00_0);
        add("postrst",  IDLE_IN,        16'h0000, 16'h0000, 9'b00_00_10_00_0);

        rst = 1'b0;
        {req0_rd, req0_wr, req0_lock, req1_rd, req1_wr, req1_lock, mem_stall} = '0;
        req0_addr = '0; req1_addr = '0; req0_wdata = '0; req1_wdata = '0;
        mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_val("reset flags", -1,
                  {7'b0, req0_gnt, req1_gnt, req0_stall, req1_stall, req0_rvalid,
                   req1_rvalid, mem_rd, mem_wr, err}, 16'h0000);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1 apply_stimulus(vecs[i], i);
            #2 check_output(vecs[i], i);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
